glm_update_sequencer: RTL

- Controller that sequences the GLM model-update stage (the op_start/op_done block that applies gradient*sample to the model BRAM).
- Splits one model into fixed-size line chunks and issues one update operation per chunk.
- Repeats the full chunk sweep once per sample, then signals completion.
- Sits between the instruction decoder and the update block; generates that block's 5x32-bit register file and op_start pulses.

---
 rtl/glm_update_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/glm_update_sequencer.sv
// Sequences GLM model-update ops: splits the model into line chunks and issues one
// update op per chunk, sweeping the whole model once per sample.
module glm_update_sequencer #(
   parameter int NUM_REGS = 5,
   parameter int CNT_W    = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic                     abort,
   input  logic [15:0]              cfg_model_offset,
   input  logic [15:0]              cfg_model_length,
   input  logic [15:0]              cfg_chunk_length,
   input  logic [CNT_W-1:0]         cfg_num_samples,
   input  logic                     cfg_write_forward,
   output logic                     upd_start,
   output logic [NUM_REGS-1:0][31:0] upd_regs,
   input  logic                     upd_done,
   output logic                     busy,
   output logic                     done,
   output logic                     aborted,
   output logic [CNT_W-1:0]         samples_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ADVANCE,
      S_FINISH
   } state_t;

   state_t                      r_state;
   logic [15:0]                 r_offset;
   logic [15:0]                 r_length;
   logic [15:0]                 r_chunk;
   logic [CNT_W-1:0]            r_num_samples;
   logic                        r_wfwd;
   logic [15:0]                 r_line_ptr;
   logic [15:0]                 r_remaining;
   logic [15:0]                 r_this_len;
   logic [CNT_W-1:0]            r_sample_cnt;
   logic                        r_abort_flag;
   logic                        r_upd_start;
   logic [NUM_REGS-1:0][31:0]   r_upd_regs;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_aborted;

   logic [15:0]                 w_ptr_adv;
   logic [15:0]                 w_rem_adv;
   logic                        w_sweep_end;
   logic [CNT_W-1:0]            w_cnt_adv;
   logic [15:0]                 w_ptr_next;
   logic [15:0]                 w_rem_next;
   logic [15:0]                 w_iss_ptr;
   logic [15:0]                 w_iss_rem;
   logic [15:0]                 w_iss_len;
   logic [15:0]                 w_iss_line;
   logic                        w_abort_now;
   logic                        w_finish;
   logic                        w_issue;

   // ADVANCE issues the next chunk itself so upd_done -> upd_start stays at two cycles
   always_comb begin
      w_ptr_adv   = r_line_ptr + r_this_len;
      w_rem_adv   = r_remaining - r_this_len;
      w_sweep_end = (w_rem_adv == '0);
      w_cnt_adv   = r_sample_cnt + {{(CNT_W-1){1'b0}}, w_sweep_end};
      w_ptr_next  = w_sweep_end ? '0 : w_ptr_adv;
      w_rem_next  = w_sweep_end ? r_length : w_rem_adv;
      w_iss_ptr   = (r_state == S_ADVANCE) ? w_ptr_next : r_line_ptr;
      w_iss_rem   = (r_state == S_ADVANCE) ? w_rem_next : r_remaining;
      w_iss_len   = ((r_chunk == '0) || (r_chunk > w_iss_rem)) ? w_iss_rem : r_chunk;
      w_iss_line  = r_offset + w_iss_ptr;
      w_abort_now = r_abort_flag | abort;
      w_finish    = w_abort_now | (w_sweep_end && (w_cnt_adv == r_num_samples));
      w_issue     = (r_state == S_ISSUE) || ((r_state == S_ADVANCE) && !w_finish);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_offset      <= '0;
         r_length      <= '0;
         r_chunk       <= '0;
         r_num_samples <= '0;
         r_wfwd        <= 1'b0;
         r_line_ptr    <= '0;
         r_remaining   <= '0;
         r_this_len    <= '0;
         r_sample_cnt  <= '0;
         r_abort_flag  <= 1'b0;
         r_upd_start   <= 1'b0;
         r_upd_regs    <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
      end else begin
         r_upd_start <= 1'b0;
         r_done      <= 1'b0;

         if ((r_state != S_IDLE) && abort) begin
            r_abort_flag <= 1'b1;
         end

         if (w_issue) begin
            r_upd_start   <= 1'b1;
            r_this_len    <= w_iss_len;
            r_upd_regs    <= '0;
            r_upd_regs[3] <= {w_iss_len, w_iss_line};
            r_upd_regs[4] <= {31'b0, r_wfwd};
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_offset      <= cfg_model_offset;
                  r_length      <= cfg_model_length;
                  r_chunk       <= cfg_chunk_length;
                  r_num_samples <= cfg_num_samples;
                  r_wfwd        <= cfg_write_forward;
                  r_line_ptr    <= '0;
                  r_remaining   <= cfg_model_length;
                  r_sample_cnt  <= '0;
                  r_abort_flag  <= 1'b0;
                  r_aborted     <= 1'b0;
                  r_busy        <= 1'b1;
                  if ((cfg_model_length == '0) || (cfg_num_samples == '0)) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (upd_done) begin
                  r_state <= S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               r_line_ptr   <= w_ptr_next;
               r_remaining  <= w_rem_next;
               r_sample_cnt <= w_cnt_adv;
               if (w_finish) begin
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_aborted <= w_abort_now;
                  r_state   <= S_IDLE;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign upd_start    = r_upd_start;
   assign upd_regs     = r_upd_regs;
   assign busy         = r_busy;
   assign done         = r_done;
   assign aborted      = r_aborted;
   assign samples_done = r_sample_cnt;

endmodule
